// File: rtl/sdram_frame_arbiter.sv
// sdram_frame_arbiter: one-line burst write/read arbiter in front of sdram_top.
// Ping-pongs two frame buffers so the VGA side only reads complete frames.
module sdram_frame_arbiter #(
   parameter int LINES     = 750,
   parameter int WR_THRESH = 512,
   parameter int RD_THRESH = 512,
   parameter int BANK_BIT  = 22
) (
   input  logic        clk_133M_i,
   input  logic        rst_133i,
   input  logic        wr_frame_start,
   input  logic        rd_frame_start,
   input  logic [10:0] fifo_used,
   input  logic [10:0] rd_fifo_used,
   input  logic        wr_sdram_ack,
   input  logic        rd_sdram_ack,
   output logic        wr_sdram_req,
   output logic [23:0] wr_sdram_add,
   output logic        rd_sdram_req,
   output logic [23:0] rd_sdram_add,
   output logic        frame_ready,
   output logic        wr_bank,
   output logic [1:0]  st
);

   localparam int LW = $clog2(LINES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [LW-1:0] wr_line_q, wr_line_d;
   logic [LW-1:0] rd_line_q, rd_line_d;
   logic          wr_pend_q, wr_pend_d;
   logic          rd_pend_q, rd_pend_d;
   logic          wr_armed_q, wr_armed_d;
   logic          last_wr_q, last_wr_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic          rd_bank_nx_q, rd_bank_nx_d;
   logic          frame_ready_q, frame_ready_d;
   logic          wr_req_q, wr_req_d;
   logic          rd_req_q, rd_req_d;
   logic [23:0]   wr_add_q, wr_add_d;
   logic [23:0]   rd_add_q, rd_add_d;
   logic          wr_elig;
   logic          rd_elig;

   function automatic logic [23:0] line_addr(
      input logic          bank,
      input logic [LW-1:0] line
   );
      logic [23:0] a;
      a           = '0;
      a[21:9]     = 13'(line);
      a[BANK_BIT] = bank;
      return a;
   endfunction

   assign wr_elig = (fifo_used >= 11'(WR_THRESH))
                  && (wr_line_q < LW'(LINES))
                  && wr_armed_q;

   assign rd_elig = (rd_fifo_used <= 11'(RD_THRESH))
                  && (rd_line_q < LW'(LINES))
                  && frame_ready_q;

   always_comb begin
      state_d       = state_q;
      wr_line_d     = wr_line_q;
      rd_line_d     = rd_line_q;
      wr_pend_d     = wr_pend_q | wr_frame_start;
      rd_pend_d     = rd_pend_q | rd_frame_start;
      wr_armed_d    = wr_armed_q;
      last_wr_d     = last_wr_q;
      wr_bank_d     = wr_bank_q;
      rd_bank_d     = rd_bank_q;
      rd_bank_nx_d  = rd_bank_nx_q;
      frame_ready_d = frame_ready_q;
      wr_req_d      = 1'b0;
      rd_req_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // frame boundaries take the whole cycle; no grant alongside them
            if (wr_pend_d || rd_pend_d) begin
               if (rd_pend_d) begin
                  rd_line_d = '0;
                  rd_bank_d = rd_bank_nx_q;
                  rd_pend_d = 1'b0;
               end
               if (wr_pend_d) begin
                  if (wr_line_q == LW'(LINES)) begin
                     rd_bank_nx_d  = wr_bank_q;
                     wr_bank_d     = ~wr_bank_q;
                     frame_ready_d = 1'b1;
                  end
                  wr_line_d  = '0;
                  wr_armed_d = 1'b1;
                  wr_pend_d  = 1'b0;
               end
            end else if (wr_elig && (!rd_elig || !last_wr_q)) begin
               state_d  = S_WR;
               wr_req_d = 1'b1;
            end else if (rd_elig) begin
               state_d  = S_RD;
               rd_req_d = 1'b1;
            end
         end
         S_WR: begin
            if (wr_sdram_ack) begin
               if (wr_line_q < LW'(LINES)) begin
                  wr_line_d = wr_line_q + LW'(1);
               end
               state_d   = S_IDLE;
               last_wr_d = 1'b1;
            end else begin
               wr_req_d = 1'b1;
            end
         end
         S_RD: begin
            if (rd_sdram_ack) begin
               if (rd_line_q < LW'(LINES)) begin
                  rd_line_d = rd_line_q + LW'(1);
               end
               state_d   = S_IDLE;
               last_wr_d = 1'b0;
            end else begin
               rd_req_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // line/bank cannot move mid-burst, so this also holds the address
      wr_add_d = line_addr(wr_bank_d, wr_line_d);
      rd_add_d = line_addr(rd_bank_d, rd_line_d);
   end

   always_ff @(posedge clk_133M_i or negedge rst_133i) begin
      if (!rst_133i) begin
         state_q       <= S_IDLE;
         wr_line_q     <= '0;
         rd_line_q     <= '0;
         wr_pend_q     <= 1'b0;
         rd_pend_q     <= 1'b0;
         wr_armed_q    <= 1'b0;
         last_wr_q     <= 1'b0;
         wr_bank_q     <= 1'b0;
         rd_bank_q     <= 1'b0;
         rd_bank_nx_q  <= 1'b0;
         frame_ready_q <= 1'b0;
         wr_req_q      <= 1'b0;
         rd_req_q      <= 1'b0;
         wr_add_q      <= '0;
         rd_add_q      <= '0;
      end else begin
         state_q       <= state_d;
         wr_line_q     <= wr_line_d;
         rd_line_q     <= rd_line_d;
         wr_pend_q     <= wr_pend_d;
         rd_pend_q     <= rd_pend_d;
         wr_armed_q    <= wr_armed_d;
         last_wr_q     <= last_wr_d;
         wr_bank_q     <= wr_bank_d;
         rd_bank_q     <= rd_bank_d;
         rd_bank_nx_q  <= rd_bank_nx_d;
         frame_ready_q <= frame_ready_d;
         wr_req_q      <= wr_req_d;
         rd_req_q      <= rd_req_d;
         wr_add_q      <= wr_add_d;
         rd_add_q      <= rd_add_d;
      end
   end

   assign wr_sdram_req = wr_req_q;
   assign wr_sdram_add = wr_add_q;
   assign rd_sdram_req = rd_req_q;
   assign rd_sdram_add = rd_add_q;
   assign frame_ready  = frame_ready_q;
   assign wr_bank      = wr_bank_q;
   assign st           = state_q;

endmodule

// File: doc/sdram_frame_arbiter.md
Name: sdram_frame_arbiter

Overview:
- Replaces the inline write/read request logic in the top level with one 133 MHz block.
- Sits between cam2fifo/fifo2vga and sdram_top.
- Arbitrates one-line burst writes (camera FIFO to SDRAM) against one-line burst reads (SDRAM to VGA FIFO).
- Generates request/address for sdram_top and ping-pongs two frame buffers so VGA always reads a completely written frame.

Parameters:
- LINES, 750, lines per frame; row field counts 0..LINES-1.
- WR_THRESH, 512, fifo_used level (>=) that makes a line write eligible.
- RD_THRESH, 512, rd_fifo_used level (<=) that makes a line read eligible.
- BANK_BIT, 22, address bit selecting frame buffer 0/1.

Ports:
- clk_133M_i  in  1  system clock, 133 MHz.
- rst_133i  in  1  asynchronous active-low reset.
- wr_frame_start  in  1  one-cycle pulse, camera frame start (vsync rising edge, already synchronised to clk_133M_i).
- rd_frame_start  in  1  one-cycle pulse, VGA frame start (already synchronised).
- fifo_used  in  11  write-side FIFO fill level.
- rd_fifo_used  in  11  read-side FIFO fill level.
- wr_sdram_ack  in  1  one-cycle pulse, write burst finished.
- rd_sdram_ack  in  1  one-cycle pulse, read burst finished.
- wr_sdram_req  out  1  write request, held until ack.
- wr_sdram_add  out  24  write address: [BANK_BIT] buffer, [21:9] line, [8:0]=0.
- rd_sdram_req  out  1  read request, held until ack.
- rd_sdram_add  out  24  read address, same layout.
- frame_ready  out  1  at least one complete frame stored.
- wr_bank  out  1  buffer currently being written.
- st  out  2  FSM state, for LEDs/debug.

Behaviour:
- Reset (rst_133i low, async) clears every output and internal register to 0:
  - reqs, addresses, frame_ready, wr_bank, st.
  - Line counters, pending flags, last-grant flag, read bank.
- FSM states:
  - IDLE=0.
  - WR=1: wr_sdram_req=1.
  - RD=2: rd_sdram_req=1.
  - Only one request is outstanding at any time. Both reqs high together is illegal.
- Eligibility, evaluated in IDLE:
  - Write-eligible: fifo_used>=WR_THRESH and wr_line<LINES and wr_armed.
  - Read-eligible: rd_fifo_used<=RD_THRESH and rd_line<LINES and frame_ready.
- Grant:
  - One eligible: grant it.
  - Both eligible: grant the opposite of the last grant (round robin). After reset, write wins.
  - IDLE to WR/RD takes 1 cycle; req asserts on the cycle after eligibility is seen.
- WR state:
  - Hold req and address stable.
  - On wr_sdram_ack: wr_line+1, req drops next edge, return to IDLE, last grant=write.
- RD state: same rule with rd_line and rd_sdram_ack.
- Acks arriving in IDLE, or for the other channel, are ignored.
- Address outputs are registered:
  - wr_sdram_add = {wr_bank at BANK_BIT, wr_line in [21:9], zeros}; bits 23 and unused bits are 0.
  - rd_sdram_add uses rd_bank the same way.
- Write frame boundary: wr_frame_start sets wr_pend. It is applied in IDLE only, never mid-burst. When applied:
  - If wr_line==LINES (frame complete): rd_bank_next=wr_bank, wr_bank toggles, frame_ready=1.
  - In all cases: wr_line=0, wr_armed=1, wr_pend cleared.
  - A partial frame is discarded and rewritten in the same bank.
  - wr_armed=0 after reset, so writing starts at the first frame boundary.
- Read frame boundary: rd_frame_start sets rd_pend. Applied in IDLE: rd_line=0, rd_bank=rd_bank_next, rd_pend cleared.
- Pending flags are applied before eligibility in the same IDLE cycle. No request is granted in that cycle.
- Simultaneous wr/rd pending: both are applied together. rd_bank takes the value of rd_bank_next from before the toggle in that cycle.
- wr_line/rd_line saturate at LINES. No further requests are issued until the next matching frame start.
- A second start pulse while still pending is absorbed; the flag stays set.
- Reset mid-burst drops req immediately, asynchronously.

Test Plan:
- Reset, then fifo_used=600 with no wr_frame_start -> no wr_sdram_req. After a wr_frame_start pulse -> req 2 cycles later, wr_sdram_add=0. Ack -> next req has add[21:9]=1.
- Run 750 write acks, then wr_frame_start -> frame_ready=1, wr_bank=1, next wr_sdram_add=0x400000, and no 751st write before the start pulse.
- Both eligible continuously with immediate acks -> grants alternate W,R,W,R. Never both reqs high.
- wr_frame_start arrives during WR before ack -> req and address are unchanged until ack. Line resets afterwards, next address line=0.
- Only 300 lines written, then wr_frame_start -> wr_bank unchanged, frame_ready unchanged, line=0.
- After frame 1 completes, rd_frame_start -> reads use bank 0 (add[22]=0). rd_fifo_used=513 -> no read. Reads stop at line 750.
